// File: rtl/core_pkg.sv
// Shared core types for the load/store memory path.
// Holds the responder FSM states, the request bundle and lane count.
package core_pkg;

    localparam int CORE_DATA_WIDTH = 32;
    localparam int CORE_ADDR_WIDTH = 7;
    localparam int CORE_NUM_LANES  = CORE_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_rsp_state_t;

    typedef struct packed {
        logic                       write;
        logic [CORE_ADDR_WIDTH-1:0] addr;
        logic [CORE_DATA_WIDTH-1:0] wdata;
        logic [CORE_NUM_LANES-1:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/byte_en_ram.sv
// Synchronous word array with per-byte-lane write enables.
// Ports: we_i/waddr_i/wdata_i write side; re_i/raddr_i -> registered rdata_o.
// The read register only updates when re_i is set, so data holds afterwards.
// Reset clears every word and the read register.
module byte_en_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 5
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (we_i[l]) begin
                    mem_q[waddr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
                end
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store memory responder: one outstanding request, WAIT_STATES extra
// cycles of latency, error response on misaligned addresses.
// Ports: req_* request handshake in, rsp_* response handshake out.
module data_mem_responder
    import core_pkg::*;
#(
    parameter int DATA_WIDTH  = CORE_DATA_WIDTH,
    parameter int ADDR_WIDTH  = CORE_ADDR_WIDTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);

    mem_rsp_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    mem_req_t       req_q, req_d;
    logic           err_q, err_d;

    // Transaction being committed: straight from the inputs when the
    // commit happens in the accept cycle, otherwise the latched copy.
    mem_req_t         txn;
    logic             commit;
    logic             misaligned;
    logic [LANES-1:0] ram_we;
    logic             ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        commit      = 1'b0;
        txn         = req_q;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                txn = '{write: req_write_i, addr: req_addr_i,
                        wdata: req_wdata_i, wstrb: req_wstrb_i};
                if (req_valid_i) begin
                    req_d = txn;
                    cnt_d = '0;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAST) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        misaligned = |txn.addr[OFF_W-1:0];
        if (commit) begin
            err_d = misaligned;
        end
        ram_we = '0;
        if (commit && txn.write && !misaligned) begin
            ram_we = txn.wstrb;
        end
        ram_re = commit && !txn.write && !misaligned;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    byte_en_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .we_i   (ram_we),
        .waddr_i(txn.addr[ADDR_WIDTH-1:OFF_W]),
        .wdata_i(txn.wdata),
        .re_i   (ram_re),
        .raddr_i(txn.addr[ADDR_WIDTH-1:OFF_W]),
        .rdata_o(ram_rdata)
    );

    // Read data is only shown for a good load while the response is up.
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = err_q;
    assign rsp_rdata_o = (rsp_valid_o && !req_q.write && !err_q)
                         ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: scoreboard of expected responses,
// with a second instance built with zero wait states.
module tb_data_mem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [6:0]  req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_write = 1'b0;
    logic [6:0]  z_req_addr = '0;
    logic [31:0] z_req_wdata = '0;
    logic [3:0]  z_req_wstrb = '0;
    logic        z_rsp_valid;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem_m [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    data_mem_responder #(.WAIT_STATES(WS)) u_dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_write_i(req_write_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o)
    );

    data_mem_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_valid_i(z_req_valid),
        .req_ready_o(z_req_ready),
        .req_write_i(z_req_write),
        .req_addr_i (z_req_addr),
        .req_wdata_i(z_req_wdata),
        .req_wstrb_i(z_req_wstrb),
        .rsp_valid_o(z_rsp_valid),
        .rsp_ready_i(1'b1),
        .rsp_rdata_o(z_rsp_rdata),
        .rsp_err_o  (z_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic w, input logic [6:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic err);
        logic [4:0] idx;
        idx = a[6:2];
        rd  = '0;
        err = 1'b0;
        if (a[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (w) begin
            for (int l = 0; l < 4; l++) begin
                if (s[l]) mem_m[idx][l*8 +: 8] = d[l*8 +: 8];
            end
        end else begin
            rd = mem_m[idx];
        end
    endtask

    task automatic send(input logic w, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        req_wstrb_i = s;
        for (int k = 0; k < 30; k++) begin
            if (req_ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 64'(got), 64'd1);
        e.acc = cyc;
        model(w, a, d, s, e.rd, e.err);
        sbq.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", 64'(got), 64'd1);
    endtask

    task automatic recv(input string tag);
        exp_t e;
        wait_rsp();
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sbq.pop_front();
            check({tag, "_latency"}, 64'(cyc - e.acc), 64'(WS + 1));
            check({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(e.rd));
            check({tag, "_err"}, 64'(rsp_err_o), 64'(e.err));
        end
        @(negedge clk);
        check({tag, "_clear"},
              64'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=done");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        for (int i = 0; i < 32; i++) mem_m[i] = '0;

        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rdata", 64'(rsp_rdata_o), 64'd0);
        check("rst_err", 64'(rsp_err_o), 64'd0);

        send(1'b0, 7'h10, 32'h0, 4'h0);
        recv("ld10");

        send(1'b1, 7'h08, 32'hDEADBEEF, 4'hF);
        recv("st08");
        send(1'b0, 7'h08, 32'h0, 4'h0);
        recv("ld08");

        send(1'b1, 7'h0C, 32'h11223344, 4'hF);
        recv("st0c");
        send(1'b1, 7'h0C, 32'hAABBCCDD, 4'b0101);
        recv("st0c_strb");
        send(1'b0, 7'h0C, 32'h0, 4'h0);
        check("strb_model", 64'(sbq[0].rd), 64'h11BB33DD);
        recv("ld0c_strb");

        send(1'b0, 7'h0A, 32'h0, 4'h0);
        recv("ld0a_mis");
        send(1'b1, 7'h0D, 32'hFFFFFFFF, 4'hF);
        recv("st0d_mis");
        send(1'b1, 7'h0C, 32'h55555555, 4'h0);
        recv("st0c_nostrb");
        send(1'b0, 7'h0C, 32'h0, 4'h0);
        recv("ld0c_after");

        rsp_ready_i = 1'b0;
        send(1'b0, 7'h08, 32'h0, 4'h0);
        wait_rsp();
        e = sbq.pop_front();
        check("bp_latency", 64'(cyc - e.acc), 64'(WS + 1));
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 7'h0C;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid_o), 64'd1);
            check("bp_rdata", 64'(rsp_rdata_o), 64'(e.rd));
            check("bp_ready", 64'(req_ready_o), 64'd0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_after", 64'(req_ready_o), 64'd1);
        check("bp_valid_after", 64'(rsp_valid_o), 64'd0);
        e.acc = cyc;
        model(1'b0, 7'h0C, 32'h0, 4'h0, e.rd, e.err);
        sbq.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
        recv("bp_next");

        send(1'b1, 7'h04, 32'h12345678, 4'hF);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        void'(sbq.pop_back());
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        for (int k = 0; k < 6; k++) begin
            check("rst_wait_norsp", 64'(rsp_valid_o), 64'd0);
            @(negedge clk);
        end
        send(1'b0, 7'h04, 32'h0, 4'h0);
        recv("ld04_after_rst");

        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_write = 1'b1;
        z_req_addr  = 7'h00;
        z_req_wdata = 32'hCAFEF00D;
        z_req_wstrb = 4'hF;
        check("z_st_ready", 64'(z_req_ready), 64'd1);
        @(negedge clk);
        z_req_valid = 1'b0;
        check("z_st_valid", 64'(z_rsp_valid), 64'd1);
        check("z_st_rdata", 64'(z_rsp_rdata), 64'd0);
        check("z_st_err", 64'(z_rsp_err), 64'd0);
        @(negedge clk);
        check("z_st_clear", 64'(z_rsp_valid), 64'd0);
        z_req_valid = 1'b1;
        z_req_write = 1'b0;
        check("z_ld_ready", 64'(z_req_ready), 64'd1);
        @(negedge clk);
        z_req_valid = 1'b0;
        check("z_ld_valid", 64'(z_rsp_valid), 64'd1);
        check("z_ld_rdata", 64'(z_rsp_rdata), 64'hCAFEF00D);
        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_addr  = 7'h01;
        @(negedge clk);
        z_req_valid = 1'b0;
        check("z_mis_err", 64'(z_rsp_err), 64'd1);
        check("z_mis_rdata", 64'(z_rsp_rdata), 64'd0);
        n = 0;
        @(negedge clk);
        check("z_mis_clear", 64'({z_rsp_valid, z_rsp_err}), 64'(n));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
